zone_alarm_ctrl: RTL
====================

# zone_alarm_ctrl

Parametrised, clocked intruder-alarm controller for N entry sensors. Replaces the fixed four-input combinational alarm with a state machine that adds arm/disarm control, per-zone bypass, exit and entry delays, and latched trip reporting. Sits between the debounced sensor inputs and the siren/indicator drivers.

## Interface

Parameters:
- `NUM_ZONES`, default 4: number of sensor zones, 1..32.
- `ENTRY_ZONES`, default 4'b0001: bit i = 1 means zone i is a delayed (door) zone; 0 means an instant zone.
- `EXIT_DELAY`, default 16: cycles spent in EXIT after arming, ≥1.
- `ENTRY_DELAY`, default 16: grace cycles in ENTRY before alarm, ≥1.
- `ALARM_TIMEOUT`, default 64: alarm duration in cycles, ≥1; used only with `ZONE_ALARM_AUTORESET_EN`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `zone_open` in NUM_ZONES: HIGH = entry open.
- `zone_mask` in NUM_ZONES: HIGH = zone bypassed (ignored); live, not latched.
- `arm` in 1: arm request, sampled each edge.
- `disarm` in 1: disarm request, sampled each edge.
- `armed` out 1: HIGH in EXIT, ARMED, ENTRY, ALARM.
- `delay_active` out 1: HIGH in EXIT or ENTRY.
- `alarm` out 1: siren drive, HIGH only in ALARM.
- `arm_fail` out 1: one-cycle pulse, arm refused.
- `tripped` out NUM_ZONES: sticky record of zones that caused or occurred during a trip.

## Operation

- Active zones: `act = zone_open & ~zone_mask`; `act_entry = act & ENTRY_ZONES`; `act_inst = act & ~ENTRY_ZONES`.
- States: DISARMED, EXIT, ARMED, ENTRY, ALARM. Moore outputs decoded from registered state; `arm_fail` and `tripped` registered.
- Reset: state DISARMED, counter 0, all outputs 0.
- Priority every edge: reset > disarm > everything else. `disarm` from any state → DISARMED; `tripped` is NOT cleared by disarm.
- DISARMED: `arm` with `act == 0` → EXIT, counter = EXIT_DELAY-1, `tripped` cleared. `arm` with `act != 0` → stay, `arm_fail` = 1 for one cycle. `arm` with `disarm` the same cycle: ignored.
- EXIT: zones ignored; counter decrements; at counter 0 → ARMED.
- ARMED: `act_inst != 0` → ALARM; else `act_entry != 0` → ENTRY, counter = ENTRY_DELAY-1. Both → ALARM. `arm` ignored.
- ENTRY: `act_inst != 0` → ALARM immediately; else counter decrements; at counter 0 → ALARM.
- ALARM: held until `disarm` or reset (see Configuration).
- `tripped` |= `act` on every edge where the state is ARMED, ENTRY or ALARM.
- Counter width: clog2 of max(EXIT_DELAY, ENTRY_DELAY, ALARM_TIMEOUT) + 1; never wraps (reloaded on entry, stops at 0).

## Timing

- Inputs sampled on rising `clk`; outputs change on the same edge as the state (1-cycle input-to-output latency).
- Arm accepted at edge t: `armed`=`delay_active`=1 after t; ARMED after edge t+EXIT_DELAY.
- Instant zone sampled at edge t in ARMED/ENTRY: `alarm`=1 after edge t.
- Entry zone sampled at edge t in ARMED: ENTRY after t; ALARM after edge t+ENTRY_DELAY unless `disarm` is sampled at any edge t+1..t+ENTRY_DELAY (disarm wins at expiry edge).
- Zone open at EXIT→ARMED edge: evaluated on the following edge.
- Mask change mid-ENTRY: only instant-zone checks reflect it; the running entry countdown continues.

## Configuration

- `ZONE_ALARM_AUTORESET_EN` defined: on entering ALARM, counter = ALARM_TIMEOUT-1; at counter 0 → ARMED, `alarm` drops, `tripped` retained; a still-open zone re-trips per ARMED rules on the next edge.
- Not defined: ALARM persists until `disarm` or `reset`; ALARM_TIMEOUT unused.

## Test plan

(NUM_ZONES=4, ENTRY_ZONES=4'b0001, EXIT_DELAY=4, ENTRY_DELAY=8, ALARM_TIMEOUT=6)
- Reset with zones open and `arm`=1 → all outputs 0, state DISARMED.
- `zone_open`=4'b0100, mask 0, pulse `arm` → `arm_fail` one cycle, `armed`=0. Same with `zone_mask`=4'b0100 → accepted; ARMED exactly 4 edges later.
- ARMED, `zone_open`=4'b0001 at edge t, `disarm` at t+5 → no `alarm`, DISARMED, `tripped`=4'b0001. Repeat without disarm → `alarm`=1 after edge t+8.
- ARMED, `zone_open`=4'b1000 → `alarm`=1 after the sampling edge; in ENTRY, zone 3 opens → immediate ALARM.
- `disarm` and entry expiry on the same edge → DISARMED, `alarm` never asserted; `arm`+`disarm` together in DISARMED → no state change.
- With `ZONE_ALARM_AUTORESET_EN`: zones closed after trip → `alarm` high exactly 6 cycles, then ARMED; without macro, `alarm` stays high 100 cycles until `disarm`.

Source files
------------

// File: rtl/zone_alarm_ctrl.sv
// Intruder-alarm controller for NUM_ZONES sensors: arm/disarm, per-zone bypass, exit/entry delays, sticky trip record.
// Optional feature: define ZONE_ALARM_AUTORESET_EN to fall back from ALARM to ARMED after ALARM_TIMEOUT cycles.
module zone_alarm_ctrl #(
    parameter int                   NUM_ZONES     = 4,
    parameter logic [NUM_ZONES-1:0] ENTRY_ZONES   = 4'b0001,
    parameter int                   EXIT_DELAY    = 16,
    parameter int                   ENTRY_DELAY   = 16,
    parameter int                   ALARM_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_ZONES-1:0] zone_open,
    input  logic [NUM_ZONES-1:0] zone_mask,
    input  logic                 arm,
    input  logic                 disarm,
    output logic                 armed,
    output logic                 delay_active,
    output logic                 alarm,
    output logic                 arm_fail,
    output logic [NUM_ZONES-1:0] tripped
);

    localparam int MAX_XE    = (EXIT_DELAY > ENTRY_DELAY) ? EXIT_DELAY : ENTRY_DELAY;
    localparam int MAX_DELAY = (MAX_XE > ALARM_TIMEOUT) ? MAX_XE : ALARM_TIMEOUT;
    localparam int CNT_W     = $clog2(MAX_DELAY + 1);

    localparam logic [CNT_W-1:0] EXIT_LOAD  = CNT_W'(EXIT_DELAY - 1);
    localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_DELAY - 1);
`ifdef ZONE_ALARM_AUTORESET_EN
    localparam logic [CNT_W-1:0] ALARM_LOAD = CNT_W'(ALARM_TIMEOUT - 1);
`endif

    localparam logic [2:0] S_DISARMED = 3'd0;
    localparam logic [2:0] S_EXIT     = 3'd1;
    localparam logic [2:0] S_ARMED    = 3'd2;
    localparam logic [2:0] S_ENTRY    = 3'd3;
    localparam logic [2:0] S_ALARM    = 3'd4;

    logic [2:0]           state;
    logic [CNT_W-1:0]     cnt;
    logic [NUM_ZONES-1:0] act;
    logic [NUM_ZONES-1:0] act_entry;
    logic [NUM_ZONES-1:0] act_inst;
    logic                 watching;

    assign act       = zone_open & ~zone_mask;
    assign act_entry = act & ENTRY_ZONES;
    assign act_inst  = act & ~ENTRY_ZONES;
    assign watching  = (state == S_ARMED) || (state == S_ENTRY) || (state == S_ALARM);

    assign armed        = (state != S_DISARMED);
    assign delay_active = (state == S_EXIT) || (state == S_ENTRY);
    assign alarm        = (state == S_ALARM);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_DISARMED;
            cnt      <= '0;
            arm_fail <= 1'b0;
            tripped  <= '0;
        end else begin
            arm_fail <= 1'b0;
            // Trip record accumulates even on the disarm edge; only a fresh arm clears it.
            if (watching) begin
                tripped <= tripped | act;
            end
            if (disarm) begin
                state <= S_DISARMED;
            end else begin
                case (state)
                    S_DISARMED: begin
                        if (arm) begin
                            if (act == '0) begin
                                state   <= S_EXIT;
                                cnt     <= EXIT_LOAD;
                                tripped <= '0;
                            end else begin
                                arm_fail <= 1'b1;
                            end
                        end
                    end
                    S_EXIT: begin
                        if (cnt == '0) begin
                            state <= S_ARMED;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    S_ARMED: begin
                        if (act_inst != '0) begin
                            state <= S_ALARM;
`ifdef ZONE_ALARM_AUTORESET_EN
                            cnt   <= ALARM_LOAD;
`endif
                        end else if (act_entry != '0) begin
                            state <= S_ENTRY;
                            cnt   <= ENTRY_LOAD;
                        end
                    end
                    S_ENTRY: begin
                        if ((act_inst != '0) || (cnt == '0)) begin
                            state <= S_ALARM;
`ifdef ZONE_ALARM_AUTORESET_EN
                            cnt   <= ALARM_LOAD;
`endif
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    S_ALARM: begin
`ifdef ZONE_ALARM_AUTORESET_EN
                        if (cnt == '0) begin
                            state <= S_ARMED;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
`else
                        state <= S_ALARM;
`endif
                    end
                    default: begin
                        state <= S_DISARMED;
                    end
                endcase
            end
        end
    end

endmodule
